// File: rtl/cpu_pkg.sv
// Shared pipeline types for the RV32 core: IF/ID payload, fetch FSM encoding, bubble encoding.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_data_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request, drives {pc, instr} to IF/ID.
// Latency: request accept to IF/ID capture equals memory latency; 1 instr per 2 cycles at best.
// Backpressure: pc_write=0 parks a returned instruction in buf_q (lossless); NOP bubble otherwise.
module fetch_unit
    import cpu_pkg::fetch_state_t, cpu_pkg::if_id_data_t;
    import cpu_pkg::FETCH, cpu_pkg::WAIT, cpu_pkg::HOLD, cpu_pkg::DRAIN;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output if_id_data_t fetch_out
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  instr_out;
    logic         req_fire;
    logic         resp_owed;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        instr_out = NOP_INSTR;
        req_fire  = (state_q == FETCH) && imem_req_ready;
        resp_owed = 1'b0;

        case (state_q)
            FETCH: begin
                if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    instr_out = imem_resp_data;
                    if (pc_write) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end else begin
                        buf_d   = imem_resp_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                instr_out = buf_q;
                if (pc_write) begin
                    pc_d    = pc_q + 32'd4;
                    buf_d   = NOP_INSTR;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A redirect discards whatever this cycle produced; only an in-flight response forces DRAIN.
        if (redirect_valid) begin
            pc_d      = redirect_pc & ~32'd3;
            buf_d     = NOP_INSTR;
            instr_out = NOP_INSTR;
            resp_owed = req_fire
                     || ((state_q == WAIT)  && !imem_resp_valid)
                     || ((state_q == DRAIN) && !imem_resp_valid);
            state_d   = resp_owed ? DRAIN : FETCH;
        end

        imem_req_valid  = (state_q == FETCH);
        imem_req_addr   = pc_q;
        fetch_out.pc    = pc_q;
        fetch_out.instr = instr_out;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed scenarios, then randomized traffic against a sequential-program model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = cpu_pkg::NOP_INSTR;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } cap_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    if_id_data_t fetch_out;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .fetch_out      (fetch_out)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int n_cap  = 0;

    // Memory contents: unique per word, low bits 2'b10 so never equal to the bubble.
    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[31:2] ^ 30'h2A5A_5A5A, 2'b10};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic check_true(input string name, input bit ok, input logic [31:0] got);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s got=%h (not an allowed value) t=%0t", name, got, $time);
        end
    endtask

    // Memory model: single outstanding request, per-request latency in [lat_lo, lat_hi].
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          m_out  = 1'b0;
    int          m_wcnt = 0;
    logic [31:0] m_addr = '0;

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            m_out = 1'b0;
        end else begin
            if (imem_resp_valid) m_out = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                m_out  = 1'b1;
                m_wcnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
                m_addr = imem_req_addr;
            end else if (m_out && m_wcnt > 0) begin
                m_wcnt--;
            end
        end
        #1;
        imem_resp_valid = m_out && (m_wcnt == 0);
        imem_resp_data  = imem_resp_valid ? mem_of(m_addr) : $urandom();
        #1;
    endtask

    // Reference model: IF/ID must see the sequential program starting at the last reset/redirect target.
    logic [31:0] exp_pc;
    cap_t        exp_q[$];
    logic [31:0] cap_log[$];

    always @(negedge clock) begin
        if (reset) begin
            exp_pc = RST_PC;
            exp_q.delete();
            exp_q.push_back('{pc: RST_PC, instr: mem_of(RST_PC)});
        end else begin
            check("pc_out", fetch_out.pc, exp_pc);
            check_true("instr_legal", (fetch_out.instr === NOP) || (fetch_out.instr === mem_of(exp_pc)),
                       fetch_out.instr);
            if (redirect_valid) check("redir_nop", fetch_out.instr, NOP);
            if (imem_req_valid && imem_req_ready && !redirect_valid)
                check("req_addr", imem_req_addr, exp_pc);

            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'd3;
                exp_q.delete();
                exp_q.push_back('{pc: exp_pc, instr: mem_of(exp_pc)});
            end else if (pc_write && fetch_out.instr !== NOP) begin
                if (exp_q.size() == 0) begin
                    check_true("sb_underflow", 1'b0, fetch_out.pc);
                end else begin
                    cap_t e;
                    e = exp_q.pop_front();
                    check("cap_pc", fetch_out.pc, e.pc);
                    check("cap_instr", fetch_out.instr, e.instr);
                end
                cap_log.push_back(fetch_out.pc);
                n_cap++;
                exp_pc = exp_pc + 32'd4;
                exp_q.push_back('{pc: exp_pc, instr: mem_of(exp_pc)});
            end
        end
    end

    initial begin
        int caps0;
        int hits;
        reset           = 1'b1;
        pc_write        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;

        tick(); tick();
        reset = 1'b0;                                   // cycle 0
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_pc", fetch_out.pc, RST_PC);
        check("rst_instr", fetch_out.instr, NOP);

        repeat (4) tick();                              // cycle 4
        check("stream_count", cap_log.size(), 32'd2);

        imem_req_ready = 1'b0;                          // cycles 4..6: request stalled
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_req_addr, 32'h108);
            check("stall_instr", fetch_out.instr, NOP);
        end

        tick();                                         // cycle 7: accept 0x108, IF/ID stalled
        imem_req_ready = 1'b1;
        pc_write       = 1'b0;
        tick();                                         // cycle 8: response arrives, goes to HOLD
        for (int i = 0; i < 4; i++) begin               // cycles 9..12
            tick();
            #1;
            check("hold_pc", fetch_out.pc, 32'h108);
            check("hold_instr", fetch_out.instr, mem_of(32'h108));
        end
        tick();                                         // cycle 13: captured from HOLD
        pc_write = 1'b1;
        tick();                                         // cycle 14
        #1;
        check("post_hold_pc", fetch_out.pc, 32'h10C);
        check("post_hold_caps", cap_log.size(), 32'd3);
        check("post_hold_last", cap_log[cap_log.size()-1], 32'h108);

        tick();                                         // cycle 15: capture 0x10C
        lat_lo = 3; lat_hi = 3;
        tick();                                         // cycle 16: accept 0x110, latency 3
        tick();                                         // cycle 17: WAIT without response
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check("redir_wait_instr", fetch_out.instr, NOP);
        tick();                                         // cycle 18: DRAIN
        redirect_valid = 1'b0;
        #1;
        check("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();                                         // cycle 19: stale response discarded
        #1;
        check("drain_resp_valid_seen", {31'd0, imem_resp_valid}, 32'd1);
        check("drain_req_valid2", {31'd0, imem_req_valid}, 32'd0);
        check("drain_instr", fetch_out.instr, NOP);
        lat_lo = 1; lat_hi = 1;
        tick();                                         // cycle 20: fetch target
        #1;
        check("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h200);

        tick();                                         // cycle 21: response and redirect together
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        #1;
        check("redir_resp_instr", fetch_out.instr, NOP);
        tick();                                         // cycle 22
        redirect_valid = 1'b0;
        #1;
        check("redir_resp_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("redir_resp_addr", imem_req_addr, 32'h200);
        hits = 0;
        foreach (cap_log[k]) if (cap_log[k] == 32'h110) hits++;
        check("dropped_0x110", hits, 32'd0);

        lat_lo = 3; lat_hi = 3;
        tick();                                         // cycle 23: WAIT, then reset
        reset = 1'b1;
        tick();                                         // cycle 24
        reset = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("mid_rst_pc", fetch_out.pc, RST_PC);
        check("mid_rst_instr", fetch_out.instr, NOP);

        lat_lo = 1; lat_hi = 3;
        caps0  = n_cap;
        for (int i = 0; i < 3000; i++) begin
            tick();
            imem_req_ready = ($urandom % 10) < 7;
            pc_write       = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 100) < 5;
            redirect_pc    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            reset          = ($urandom % 1000) == 0;
        end
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        check_true("random_progress", (n_cap - caps0) >= 100, n_cap - caps0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
